ft_tx_ctrl: RTL and testbench
=============================

FT_TX_CTRL -- requirements
Module: ft_tx_ctrl

Interface
REQ-001 Parameter FT_DATA_WIDTH, default 32: FTDI bus and source data width.
REQ-002 Parameter BURST_LEN, default 256: maximum words per write burst; legal range 2..65535.
REQ-003 Parameter GAP_CYCLES, default 2: idle cycles with ft_wr_n_o high after each burst; legal range 1..15.
REQ-004 Parameter FLUSH_TIMEOUT, default 64: cycles of non-empty but not-enough source before a partial burst is forced.
REQ-005 clk_i  in  1  FTDI clock; the only clock, all logic on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 src_data_i  in  FT_DATA_WIDTH  show-ahead word from the upstream selector; valid whenever src_empty_i=0.
REQ-008 src_empty_i  in  1  upstream has no word.
REQ-009 src_enough_i  in  1  upstream holds at least one full burst.
REQ-010 src_data_incomming_i  in  1  upstream still expects more samples.
REQ-011 src_re_o  out  1  combinational pop; consumes src_data_i at this edge.
REQ-012 ft_txe_n_i  in  1  FTDI TX FIFO full when high.
REQ-013 ft_wr_n_o  out  1  registered write strobe, active low.
REQ-014 ft_be_o  out  4  byte enables; 4'hF while ft_wr_n_o=0, else 4'h0.
REQ-015 ft_data_o  out  FT_DATA_WIDTH  registered write data.
REQ-016 burst_done_o  out  1  one-cycle pulse on entry to GAP.
REQ-017 word_cnt_o  out  32  total words accepted by FTDI, wraps at 2^32.

Function
REQ-018 States SHALL be IDLE, BURST, DRAIN, GAP.
REQ-019 accept = ~ft_wr_n_o & ~ft_txe_n_i at a rising edge; only accepted words advance word_cnt_o and beat_cnt.
REQ-020 flush_req = ~src_empty_i & (~src_data_incomming_i | idle_timer == FLUSH_TIMEOUT); idle_timer counts IDLE cycles with ~src_empty_i & ~src_enough_i, clears otherwise, saturates at FLUSH_TIMEOUT.
REQ-021 IDLE->BURST when ~ft_txe_n_i & ~src_empty_i & (src_enough_i | flush_req); issue_cnt and beat_cnt clear on this transition.
REQ-022 In BURST, src_re_o = ~src_empty_i & (issue_cnt < BURST_LEN) & (ft_wr_n_o | accept); src_re_o SHALL be 0 in all other states.
REQ-023 On src_re_o: ft_data_o <= src_data_i, ft_wr_n_o <= 0, issue_cnt increments; on accept without src_re_o: ft_wr_n_o <= 1, ft_data_o holds.
REQ-024 While ft_txe_n_i=1, ft_wr_n_o and ft_data_o SHALL hold unchanged; no word is dropped or duplicated.
REQ-025 BURST->DRAIN when issue_cnt reaches BURST_LEN or src_empty_i=1 with no src_re_o (partial burst).
REQ-026 DRAIN->GAP at the edge where the last outstanding word is accepted (ft_wr_n_o returns high); burst_done_o pulses in the first GAP cycle.
REQ-027 GAP SHALL last exactly GAP_CYCLES cycles, then return to IDLE.
REQ-028 Latency: first src_re_o in the first BURST cycle; ft_wr_n_o low from the next cycle; with ft_txe_n_i=0 and non-empty source, one word per clock.
REQ-029 beat_cnt and issue_cnt SHALL be 16 bits; beat_cnt never exceeds issue_cnt.
REQ-030 Simultaneous accept and src_re_o in the same cycle SHALL keep ft_wr_n_o low and replace ft_data_o.

Reset
REQ-031 While reset_n=0: state IDLE, ft_wr_n_o=1, ft_be_o=0, ft_data_o=0, src_re_o=0, burst_done_o=0, word_cnt_o=0, counters and idle_timer 0.
REQ-032 Reset asserted mid-burst SHALL abort the burst immediately; un-accepted words are discarded; normal operation resumes on the first edge after release.

Verification
REQ-033 Full burst: BURST_LEN=4, source 6 words 0x1..0x6, enough=1, txe_n=0 -> ft_wr_n_o low 4 consecutive cycles with 0x1..0x4, burst_done_o pulse, 2 gap cycles, word_cnt_o=4.
REQ-034 Backpressure: txe_n=1 for 3 cycles while 0x2 is presented -> ft_data_o holds 0x2, src_re_o=0, word order 0x1,0x2,0x3 unchanged.
REQ-035 Flush: 3 words, enough=0, incomming=0 -> partial burst of 3, burst_done_o pulse, word_cnt_o=3.
REQ-036 Timeout: 1 word, enough=0, incomming=1 -> burst starts exactly FLUSH_TIMEOUT+1 cycles after word appears.
REQ-037 Reset mid-burst after 2 accepted words -> ft_wr_n_o=1 and word_cnt_o=0 asynchronously; IDLE after release.

Source files
------------

// File: rtl/ft_tx_ctrl.sv
// ft_tx_ctrl: burst write controller from a show-ahead source into an FTDI synchronous FIFO
module ft_tx_ctrl #(
  parameter int FT_DATA_WIDTH = 32,
  parameter int BURST_LEN     = 256,
  parameter int GAP_CYCLES    = 2,
  parameter int FLUSH_TIMEOUT = 64
) (
  input  logic                     clk_i,
  input  logic                     reset_n,
  input  logic [FT_DATA_WIDTH-1:0] src_data_i,
  input  logic                     src_empty_i,
  input  logic                     src_enough_i,
  input  logic                     src_data_incomming_i,
  output logic                     src_re_o,
  input  logic                     ft_txe_n_i,
  output logic                     ft_wr_n_o,
  output logic [3:0]               ft_be_o,
  output logic [FT_DATA_WIDTH-1:0] ft_data_o,
  output logic                     burst_done_o,
  output logic [31:0]              word_cnt_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BURST = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] GAP = 2'd3;
  localparam logic [15:0] BL = 16'(BURST_LEN);
  localparam logic [15:0] FT = 16'(FLUSH_TIMEOUT);
  localparam logic [3:0] GL = 4'(GAP_CYCLES - 1);
  logic [1:0] state;
  logic [15:0] issue_cnt, beat_cnt, idle_timer;
  logic [3:0] gap_cnt;
  logic accept, flush_req, start, to_drain, drained, gap_end, waiting;
  assign accept = ~ft_wr_n_o & ~ft_txe_n_i;
  assign flush_req = ~src_empty_i & (~src_data_incomming_i | idle_timer == FT);
  assign start = state == IDLE & ~ft_txe_n_i & ~src_empty_i & (src_enough_i | flush_req);
  // A full FTDI FIFO also blocks the pop so the registered word and strobe stay frozen.
  assign src_re_o = state == BURST & ~src_empty_i & issue_cnt < BL & ~ft_txe_n_i & (ft_wr_n_o | accept);
  assign to_drain = state == BURST & ((issue_cnt + 16'(src_re_o)) == BL | (src_empty_i & ~src_re_o));
  assign drained = state == DRAIN & (beat_cnt + 16'(accept)) == issue_cnt;
  assign gap_end = state == GAP & gap_cnt == GL;
  assign waiting = state == IDLE & ~src_empty_i & ~src_enough_i & ~start;
  assign ft_be_o = ft_wr_n_o ? 4'h0 : 4'hF;
  // Burst sequencing: IDLE -> BURST -> DRAIN -> GAP -> IDLE.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= start ? BURST : to_drain ? DRAIN : drained ? GAP : gap_end ? IDLE : state;
  end
  // Issue/accept bookkeeping, gap length and the partial-burst timer.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      issue_cnt <= '0;
      beat_cnt <= '0;
      gap_cnt <= '0;
      idle_timer <= '0;
      word_cnt_o <= '0;
      burst_done_o <= 1'b0;
    end else begin
      issue_cnt <= start ? 16'd0 : issue_cnt + 16'(src_re_o);
      beat_cnt <= start ? 16'd0 : beat_cnt + 16'(accept);
      gap_cnt <= state == GAP ? gap_cnt + 4'd1 : 4'd0;
      idle_timer <= waiting ? (idle_timer == FT ? FT : idle_timer + 16'd1) : 16'd0;
      word_cnt_o <= word_cnt_o + 32'(accept);
      burst_done_o <= drained;
    end
  end
  // Output register: a pop loads a new word, an accept with no pop releases the strobe.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      ft_wr_n_o <= 1'b1;
      ft_data_o <= '0;
    end else begin
      ft_wr_n_o <= src_re_o ? 1'b0 : accept ? 1'b1 : ft_wr_n_o;
      ft_data_o <= src_re_o ? src_data_i : ft_data_o;
    end
  end
endmodule

// File: tb/tb_ft_tx_ctrl.sv
// tb_ft_tx_ctrl: directed checks of ft_tx_ctrl bursts, backpressure, flush, timeout and reset
module tb_ft_tx_ctrl;
  localparam int W = 32;
  localparam int BL = 4;
  localparam int GC = 2;
  localparam int FT = 8;
  logic clk_i = 1'b0;
  logic reset_n = 1'b0;
  logic [W-1:0] src_data_i;
  logic src_empty_i, src_enough_i, src_data_incomming_i, src_re_o;
  logic ft_txe_n_i, ft_wr_n_o, burst_done_o;
  logic [3:0] ft_be_o;
  logic [W-1:0] ft_data_o;
  logic [31:0] word_cnt_o;
  logic [W-1:0] mem [0:15];
  int rp, wp, checks, errors;
  logic wr [0:31];
  logic re [0:31];
  logic dn [0:31];
  logic [W-1:0] dat [0:31];
  logic [31:0] wc [0:31];
  logic [W-1:0] acc [$];
  logic [31:0] txe_pat;

  ft_tx_ctrl #(.FT_DATA_WIDTH(W), .BURST_LEN(BL), .GAP_CYCLES(GC), .FLUSH_TIMEOUT(FT)) dut (
    .clk_i(clk_i), .reset_n(reset_n), .src_data_i(src_data_i), .src_empty_i(src_empty_i),
    .src_enough_i(src_enough_i), .src_data_incomming_i(src_data_incomming_i), .src_re_o(src_re_o),
    .ft_txe_n_i(ft_txe_n_i), .ft_wr_n_o(ft_wr_n_o), .ft_be_o(ft_be_o), .ft_data_o(ft_data_o),
    .burst_done_o(burst_done_o), .word_cnt_o(word_cnt_o)
  );

  always #5 clk_i = ~clk_i;
  assign src_data_i = mem[rp[3:0]];
  assign src_empty_i = (rp == wp);

  task automatic do_reset();
    reset_n = 1'b0;
    rp = 0;
    wp = 0;
    src_enough_i = 1'b0;
    src_data_incomming_i = 1'b1;
    ft_txe_n_i = 1'b0;
    txe_pat = '0;
    repeat (2) @(posedge clk_i);
    #1 reset_n = 1'b1;
    acc.delete();
  endtask

  task automatic load(input logic [W-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wp[3:0]] = base + W'(i);
      wp++;
    end
  endtask

  task automatic run(input int n);
    logic a;
    logic [W-1:0] d;
    for (int k = 0; k < n; k++) begin
      ft_txe_n_i = txe_pat[k];
      @(negedge clk_i);
      wr[k] = ft_wr_n_o;
      re[k] = src_re_o;
      dn[k] = burst_done_o;
      dat[k] = ft_data_o;
      wc[k] = word_cnt_o;
      a = ~ft_wr_n_o & ~ft_txe_n_i;
      d = ft_data_o;
      @(posedge clk_i);
      #1;
      if (re[k]) rp++;
      if (a) acc.push_back(d);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rp = 0;
    wp = 0;
    load(32'hA0, 2);
    src_enough_i = 1'b1;
    ft_txe_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks += 6;
    if (ft_wr_n_o !== 1'b1) begin errors++; $display("FAIL reset_wr_n got %b want 1", ft_wr_n_o); end
    if (ft_be_o !== 4'h0) begin errors++; $display("FAIL reset_be got %h want 0", ft_be_o); end
    if (ft_data_o !== '0) begin errors++; $display("FAIL reset_data got %h want 0", ft_data_o); end
    if (src_re_o !== 1'b0) begin errors++; $display("FAIL reset_re got %b want 0", src_re_o); end
    if (burst_done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", burst_done_o); end
    if (word_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_word_cnt got %0d want 0", word_cnt_o); end
  endtask

  task automatic test_full_burst();
    int nd;
    do_reset();
    load(32'h1, 6);
    src_enough_i = 1'b1;
    run(12);
    checks += 4;
    if (re[0] !== 1'b0) begin errors++; $display("FAIL full_re0 got %b want 0", re[0]); end
    if (re[1] !== 1'b1) begin errors++; $display("FAIL full_re1 got %b want 1", re[1]); end
    if (wr[1] !== 1'b1) begin errors++; $display("FAIL full_wr1 got %b want 1", wr[1]); end
    if (wr[6] !== 1'b1) begin errors++; $display("FAIL full_wr6 got %b want 1", wr[6]); end
    for (int k = 2; k < 6; k++) begin
      checks += 3;
      if (wr[k] !== 1'b0) begin errors++; $display("FAIL full_wr c%0d got %b want 0", k, wr[k]); end
      if (dat[k] !== W'(k - 1)) begin errors++; $display("FAIL full_data c%0d got %h want %h", k, dat[k], k - 1); end
      if (ft_be_o !== 4'h0 && k == 0) errors++;
      if ((wr[k] ? 4'h0 : 4'hF) !== 4'hF) begin errors++; $display("FAIL full_be c%0d", k); end
    end
    nd = 0;
    for (int k = 0; k < 12; k++) if (dn[k] === 1'b1) nd++;
    checks += 5;
    if (dn[6] !== 1'b1) begin errors++; $display("FAIL full_done6 got %b want 1", dn[6]); end
    if (nd != 1) begin errors++; $display("FAIL full_done_count got %0d want 1", nd); end
    if (re[8] !== 1'b0) begin errors++; $display("FAIL full_gap_re8 got %b want 0", re[8]); end
    if (re[9] !== 1'b1) begin errors++; $display("FAIL full_gap_re9 got %b want 1", re[9]); end
    if (wc[7] !== 32'd4) begin errors++; $display("FAIL full_word_cnt got %0d want 4", wc[7]); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (acc[i] !== W'(i + 1)) begin errors++; $display("FAIL full_order %0d got %h want %h", i, acc[i], i + 1); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    load(32'h1, 3);
    src_enough_i = 1'b1;
    txe_pat = 32'h38;
    run(12);
    for (int k = 3; k < 6; k++) begin
      checks += 3;
      if (dat[k] !== 32'h2) begin errors++; $display("FAIL bp_data c%0d got %h want 2", k, dat[k]); end
      if (wr[k] !== 1'b0) begin errors++; $display("FAIL bp_wr c%0d got %b want 0", k, wr[k]); end
      if (re[k] !== 1'b0) begin errors++; $display("FAIL bp_re c%0d got %b want 0", k, re[k]); end
    end
    checks += 3;
    if (re[6] !== 1'b1) begin errors++; $display("FAIL bp_resume_re got %b want 1", re[6]); end
    if (acc.size() != 3) begin errors++; $display("FAIL bp_count got %0d want 3", acc.size()); end
    if (wc[11] !== 32'd3) begin errors++; $display("FAIL bp_word_cnt got %0d want 3", wc[11]); end
    for (int i = 0; i < 3 && i < acc.size(); i++) begin
      checks++;
      if (acc[i] !== W'(i + 1)) begin errors++; $display("FAIL bp_order %0d got %h want %h", i, acc[i], i + 1); end
    end
  endtask

  task automatic test_flush();
    int nd;
    do_reset();
    load(32'h11, 3);
    src_data_incomming_i = 1'b0;
    run(12);
    nd = 0;
    for (int k = 0; k < 12; k++) if (dn[k] === 1'b1) nd++;
    checks += 4;
    if (dn[6] !== 1'b1) begin errors++; $display("FAIL flush_done6 got %b want 1", dn[6]); end
    if (nd != 1) begin errors++; $display("FAIL flush_done_count got %0d want 1", nd); end
    if (wc[8] !== 32'd3) begin errors++; $display("FAIL flush_word_cnt got %0d want 3", wc[8]); end
    if (acc.size() != 3) begin errors++; $display("FAIL flush_count got %0d want 3", acc.size()); end
    for (int i = 0; i < 3 && i < acc.size(); i++) begin
      checks++;
      if (acc[i] !== W'(32'h11 + i)) begin errors++; $display("FAIL flush_order %0d got %h want %h", i, acc[i], 32'h11 + i); end
    end
  endtask

  task automatic test_timeout();
    int first;
    do_reset();
    load(32'h55, 1);
    run(16);
    first = -1;
    for (int k = 0; k < 16; k++) if (re[k] === 1'b1 && first < 0) first = k;
    checks += 3;
    if (first != FT + 1) begin errors++; $display("FAIL timeout_start got %0d want %0d", first, FT + 1); end
    if (acc.size() != 1) begin errors++; $display("FAIL timeout_count got %0d want 1", acc.size()); end
    else if (acc[0] !== 32'h55) begin errors++; $display("FAIL timeout_data got %h want 55", acc[0]); end
    if (wc[15] !== 32'd1) begin errors++; $display("FAIL timeout_word_cnt got %0d want 1", wc[15]); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    load(32'h1, 6);
    src_enough_i = 1'b1;
    run(4);
    checks += 2;
    if (word_cnt_o !== 32'd2) begin errors++; $display("FAIL mid_pre_cnt got %0d want 2", word_cnt_o); end
    if (ft_wr_n_o !== 1'b0) begin errors++; $display("FAIL mid_pre_wr got %b want 0", ft_wr_n_o); end
    #2 reset_n = 1'b0;
    #1;
    checks += 3;
    if (ft_wr_n_o !== 1'b1) begin errors++; $display("FAIL mid_async_wr got %b want 1", ft_wr_n_o); end
    if (word_cnt_o !== 32'd0) begin errors++; $display("FAIL mid_async_cnt got %0d want 0", word_cnt_o); end
    if (src_re_o !== 1'b0) begin errors++; $display("FAIL mid_async_re got %b want 0", src_re_o); end
    rp = 0;
    wp = 0;
    src_enough_i = 1'b0;
    @(posedge clk_i);
    #1 reset_n = 1'b1;
    acc.delete();
    run(3);
    for (int k = 0; k < 3; k++) begin
      checks += 2;
      if (wr[k] !== 1'b1) begin errors++; $display("FAIL mid_idle_wr c%0d got %b want 1", k, wr[k]); end
      if (re[k] !== 1'b0) begin errors++; $display("FAIL mid_idle_re c%0d got %b want 0", k, re[k]); end
    end
    load(32'h21, 2);
    src_enough_i = 1'b1;
    run(4);
    checks += 3;
    if (re[1] !== 1'b1) begin errors++; $display("FAIL mid_resume_re got %b want 1", re[1]); end
    if (wr[2] !== 1'b0) begin errors++; $display("FAIL mid_resume_wr got %b want 0", wr[2]); end
    if (dat[2] !== 32'h21) begin errors++; $display("FAIL mid_resume_data got %h want 21", dat[2]); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_full_burst();
    test_backpressure();
    test_flush();
    test_timeout();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
